// File: rtl/bcp_imply_arb_pkg.sv
// Shared types and defaults for the BCP implication arbiter.
package bcp_imply_arb_pkg;

    localparam int unsigned LitW             = 16;
    localparam int unsigned NumPeDefault     = 4;
    localparam int unsigned FifoDepthDefault = 4;

    // Signed literal; value 0 means "no literal".
    typedef logic signed [LitW-1:0] lit_t;

    typedef enum logic [1:0] {
        ArbRun     = 2'd0,
        ArbFlush   = 2'd1,
        ArbWaitClr = 2'd2
    } arb_state_t;

    // Complement of a literal (negation in two's complement).
    function automatic lit_t lit_neg(input lit_t l);
        return -l;
    endfunction

endpackage

// File: rtl/bcp_imply_arb_imply_fifo.sv
// Synchronous per-PE implication FIFO with flush; head is read combinationally.
module bcp_imply_arb_imply_fifo
    import bcp_imply_arb_pkg::*;
#(
    parameter int unsigned  Depth = FifoDepthDefault,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [LitW-1:0] push_data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [LitW-1:0] head_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [LitW-1:0] mem_q [Depth];
    logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Next-state pointers and count; flush wins over push/pop.
    always_comb begin
        // A push into a full FIFO is accepted only if the same cycle pops.
        push_ok = push_i && !flush_i && (!full_o || pop_i);
        pop_ok  = pop_i && !flush_i && !empty_o;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + PtrW'(1);
            if (pop_ok)  rd_d = rd_q + PtrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/bcp_imply_arb.sv
// Implication arbiter: captures PE implications into per-PE FIFOs, drains them
// round-robin into the unit-clause queue, and sequences conflicts.
module bcp_imply_arb
    import bcp_imply_arb_pkg::*;
#(
    parameter int unsigned  NumPe     = NumPeDefault,
    parameter int unsigned  FifoDepth = FifoDepthDefault,
    localparam int unsigned IdW       = (NumPe > 1) ? $clog2(NumPe) : 1,
    localparam int unsigned CntW      = $clog2(FifoDepth) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumPe-1:0]      pe_imply_valid_i,
    input  logic [NumPe*LitW-1:0] pe_imply_lit_i,
    input  logic [NumPe-1:0]      pe_conflict_i,
    output logic                  arb2bcp_halt_o,
    output logic                  arb2ucq_valid_o,
    output logic [LitW-1:0]       arb2ucq_lit_o,
    input  logic                  ucq2arb_full_i,
    output logic                  conflict_o,
    output logic [IdW-1:0]        conflict_pe_id_o,
    input  logic                  conflict_clear_i,
    output logic                  overflow_err_o,
    output logic                  idle_o
);

    lit_t            pe_lit    [NumPe];
    logic [LitW-1:0] fifo_head [NumPe];
    logic [CntW-1:0] fifo_cnt  [NumPe];
    logic [NumPe-1:0] fifo_full, fifo_empty;
    logic [NumPe-1:0] cand, push_req, push_en, pop_vec;

    arb_state_t     state_q, state_d;
    logic [IdW-1:0] rr_q, rr_d, cid_q, cid_d;
    logic           ovf_q, ovf_d;

    logic [IdW-1:0] comp_id, conf_id, grant_id;
    logic           comp_hit, eff_conflict, run, grant_vld, pop, flush;

    assign run   = (state_q == ArbRun);
    assign flush = (state_q == ArbFlush);

    for (genvar i = 0; i < NumPe; i++) begin : g_pe
        assign pe_lit[i] = lit_t'(pe_imply_lit_i[i*LitW +: LitW]);

        bcp_imply_arb_imply_fifo #(
            .Depth (FifoDepth)
        ) u_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .push_i      (push_en[i]),
            .push_data_i (pe_lit[i]),
            .pop_i       (pop_vec[i]),
            .flush_i     (flush),
            .head_o      (fifo_head[i]),
            .count_o     (fifo_cnt[i]),
            .full_o      (fifo_full[i]),
            .empty_o     (fifo_empty[i])
        );
    end

    // Capture filtering: drop zero literals and duplicates of a lower-index PE,
    // and detect complementary pairs (id = higher PE of the first pair found).
    always_comb begin
        cand     = '0;
        push_req = '0;
        comp_hit = 1'b0;
        comp_id  = '0;
        for (int i = 0; i < NumPe; i++) begin
            cand[i] = pe_imply_valid_i[i] && (pe_lit[i] != '0);
        end
        for (int j = 0; j < NumPe; j++) begin
            push_req[j] = cand[j];
            for (int i = 0; i < NumPe; i++) begin
                if (i < j && cand[i] && cand[j]) begin
                    if (pe_lit[i] == pe_lit[j]) push_req[j] = 1'b0;
                    if (!comp_hit && (pe_lit[i] == lit_neg(pe_lit[j]))) begin
                        comp_hit = 1'b1;
                        comp_id  = IdW'(j);
                    end
                end
            end
        end
    end

    // Lowest-index explicit conflict.
    always_comb begin
        conf_id = '0;
        for (int i = NumPe - 1; i >= 0; i--) begin
            if (pe_conflict_i[i]) conf_id = IdW'(i);
        end
    end

    assign eff_conflict = run && ((|pe_conflict_i) || comp_hit);
    // Everything arriving with a conflict is discarded.
    assign push_en      = (run && !eff_conflict) ? push_req : '0;

    // Rotating-priority grant: first non-empty FIFO at or after rr_q.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int unsigned o = 0; o < NumPe; o++) begin
            idx = (32'(rr_q) + o) % NumPe;
            if (!grant_vld && !fifo_empty[IdW'(idx)]) begin
                grant_vld = 1'b1;
                grant_id  = IdW'(idx);
            end
        end
    end

    // UCQ offer and pop; a full UCQ simply holds the offer.
    always_comb begin
        arb2ucq_valid_o   = run && grant_vld;
        arb2ucq_lit_o     = arb2ucq_valid_o ? fifo_head[grant_id] : '0;
        pop               = arb2ucq_valid_o && !ucq2arb_full_i;
        pop_vec           = '0;
        pop_vec[grant_id] = pop;
    end

    // Halt when not running or any FIFO has only one free slot left, so the
    // push a PE may still emit in the halt cycle always fits.
    always_comb begin
        arb2bcp_halt_o = !run;
        for (int i = 0; i < NumPe; i++) begin
            if (fifo_cnt[i] >= CntW'(FifoDepth - 1)) arb2bcp_halt_o = 1'b1;
        end
    end

    // Arbiter FSM next state, round-robin pointer and conflict id.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cid_d   = cid_q;
        case (state_q)
            ArbRun: begin
                if (pop) rr_d = IdW'((32'(grant_id) + 1) % NumPe);
                if (eff_conflict) begin
                    state_d = ArbFlush;
                    cid_d   = (|pe_conflict_i) ? conf_id : comp_id;
                end
            end
            ArbFlush: state_d = ArbWaitClr;
            ArbWaitClr: begin
                if (conflict_clear_i) begin
                    state_d = ArbRun;
                    rr_d    = '0;
                end
            end
            default: state_d = ArbRun;
        endcase
    end

    // Sticky overflow: a push dropped because its FIFO was full and not popping.
    assign ovf_d = ovf_q || (|(push_en & fifo_full & ~pop_vec));

    // State registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ArbRun;
            rr_q    <= '0;
            cid_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cid_q   <= cid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign conflict_o       = !run;
    assign conflict_pe_id_o = cid_q;
    assign overflow_err_o   = ovf_q;
    assign idle_o           = run && (&fifo_empty) && !(|pe_imply_valid_i)
                              && !(|pe_conflict_i);

endmodule
